// File: rtl/mem_fill_arbiter_if.sv
// mem_fill_arbiter_if: miss-request, main-memory and cache-fill signals around the fill arbiter
interface mem_fill_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
);
    logic                       I_miss;
    logic [ADDR_W-1:0]          I_miss_addr;
    logic                       D_miss;
    logic [ADDR_W-1:0]          D_miss_addr;
    logic                       mem_en;
    logic [ADDR_W-1:0]          mem_addr;
    logic                       mem_data_valid;
    logic [15:0]                mem_data;
    logic [15:0]                fill_data;
    logic [$clog2(WORDS)-1:0]   fill_word;
    logic                       I_fill_wen;
    logic                       D_fill_wen;
    logic                       I_fill_done;
    logic                       D_fill_done;
    logic                       busy;

    modport slave (
        input  I_miss, I_miss_addr, D_miss, D_miss_addr, mem_data_valid, mem_data,
        output mem_en, mem_addr, fill_data, fill_word, I_fill_wen, D_fill_wen,
               I_fill_done, D_fill_done, busy
    );

    modport master (
        output I_miss, I_miss_addr, D_miss, D_miss_addr, mem_data_valid, mem_data,
        input  mem_en, mem_addr, fill_data, fill_word, I_fill_wen, D_fill_wen,
               I_fill_done, D_fill_done, busy
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: arbitrates I/D cache-miss block fills onto a pipelined main-memory read port
module mem_fill_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_fill_arbiter_if.slave bus
);
    localparam int WB = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [WB:0]       issue_q, issue_d;
    logic [WB-1:0]     ret_q, ret_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              grant_d;
    logic              mem_en;
    logic              wen;

    if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_param
        $error("mem_fill_arbiter: MEM_LAT must be >= 1 and WORDS a power of two >= 2");
    end

    // State and burst registers; owner/last_grant use 1 for the D-cache, reset aborts any burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            issue_q <= '0;
            ret_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    // Next state: round-robin grant in IDLE, count issues and returns in FILL, clear in DONE
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        ret_d   = ret_q;
        owner_d = owner_q;
        last_d  = last_q;
        base_d  = base_q;
        grant_d = bus.D_miss && !(bus.I_miss && last_q);
        if (state_q == IDLE) begin
            if (bus.I_miss || bus.D_miss) begin
                state_d = FILL;
                owner_d = grant_d;
                last_d  = grant_d;
                base_d  = (grant_d ? bus.D_miss_addr : bus.I_miss_addr) & BASE_MASK;
            end
        end else if (state_q == FILL) begin
            if (!issue_q[WB])
                issue_d = issue_q + (WB + 1)'(1);
            if (bus.mem_data_valid) begin
                ret_d = ret_q + WB'(1);
                if (ret_q == WB'(WORDS - 1))
                    state_d = DONE;
            end
        end else begin
            state_d = IDLE;
            issue_d = '0;
            ret_d   = '0;
        end
    end

    // Outputs: issue window and address, owner-steered write enables and completion pulse
    always_comb begin
        mem_en          = state_q == FILL && !issue_q[WB];
        wen             = state_q == FILL && bus.mem_data_valid;
        bus.mem_en      = mem_en;
        bus.mem_addr    = mem_en ? base_q + (ADDR_W'(issue_q) << 1) : '0;
        bus.fill_data   = bus.mem_data;
        bus.fill_word   = ret_q;
        bus.I_fill_wen  = wen && !owner_q;
        bus.D_fill_wen  = wen && owner_q;
        bus.I_fill_done = state_q == DONE && !owner_q;
        bus.D_fill_done = state_q == DONE && owner_q;
        bus.busy        = state_q != IDLE;
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed fill scenarios checked every cycle against a timeline model of the arbiter
module tb_mem_fill_arbiter;
    localparam int MEM_LAT  = 4;
    localparam int WORDS    = 8;
    localparam int ADDR_W   = 16;
    localparam int FILL_END = WORDS + MEM_LAT + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fill_arbiter_if #(.ADDR_W(ADDR_W), .WORDS(WORDS)) bus ();

    mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Main memory: fixed MEM_LAT read pipeline, data is the word address scrambled by a constant
    logic [MEM_LAT-1:0] pv = '0;
    logic [ADDR_W-1:0]  pa [MEM_LAT];
    always @(posedge clk) begin
        pv <= {pv[MEM_LAT-2:0], bus.mem_en};
        pa[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end
    assign bus.mem_data_valid = pv[MEM_LAT-1];
    assign bus.mem_data       = pa[MEM_LAT-1] ^ 16'h5A3C;

    int cyc = 0, t0 = 0, n_chk = 0, n_err = 0;
    bit m_act = 0, m_own = 0, m_last = 0;
    int m_g = 0;
    logic [15:0] m_base = '0;
    int en_cnt, en_first, en_last, wi, wd, w_first, w_last, di, dd;
    logic [15:0] a_first, a_last, d_first;
    logic [23:0] seq;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: a grant at cycle g means issue at g+1..g+WORDS, word k lands at g+1+MEM_LAT+k, done at g+FILL_END
    task automatic model_step();
        int d, k, r;
        logic e_en, e_wen;
        logic [15:0] e_addr;
        d      = cyc - m_g;
        k      = d - 1 - MEM_LAT;
        e_en   = m_act && d >= 1 && d <= WORDS;
        e_addr = e_en ? m_base + 16'(2 * (d - 1)) : 16'h0;
        e_wen  = m_act && k >= 0 && k < WORDS;
        chk("busy", bus.busy, m_act);
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("I_fill_wen", bus.I_fill_wen, e_wen && !m_own);
        chk("D_fill_wen", bus.D_fill_wen, e_wen && m_own);
        chk("I_fill_done", bus.I_fill_done, m_act && d == FILL_END && !m_own);
        chk("D_fill_done", bus.D_fill_done, m_act && d == FILL_END && m_own);
        if (e_wen) begin
            chk("fill_word", bus.fill_word, k);
            chk("fill_data", bus.fill_data, (m_base + 16'(2 * k)) ^ 16'h5A3C);
        end
        r = cyc - t0;
        if (bus.mem_en) begin
            if (en_cnt == 0) begin en_first = r; a_first = bus.mem_addr; end
            en_last = r; a_last = bus.mem_addr; en_cnt++;
        end
        if (bus.I_fill_wen || bus.D_fill_wen) begin
            if (wi + wd == 0) begin w_first = r; d_first = bus.fill_data; end
            w_last = r; seq = {seq[20:0], bus.fill_word};
        end
        if (bus.I_fill_wen) wi++;
        if (bus.D_fill_wen) wd++;
        if (bus.I_fill_done) di = r;
        if (bus.D_fill_done) dd = r;
        if (!rst_n) begin
            m_act = 0; m_last = 0;
        end else if (m_act) begin
            if (d == FILL_END) m_act = 0;
        end else if (bus.I_miss || bus.D_miss) begin
            m_own  = (bus.I_miss && bus.D_miss) ? !m_last : bus.D_miss;
            m_last = m_own;
            m_base = (m_own ? bus.D_miss_addr : bus.I_miss_addr) & ~16'(2 * WORDS - 1);
            m_g    = cyc;
            m_act  = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tickn(input int n);
        repeat (n) tick();
    endtask

    task automatic start_test();
        t0 = cyc; en_cnt = 0; en_first = -1; en_last = -1; wi = 0; wd = 0;
        w_first = -1; w_last = -1; di = -1; dd = -1; seq = '0;
        a_first = '0; a_last = '0; d_first = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(bus.I_fill_done || bus.D_fill_done) && n < 40) begin tick(); n++; end
        chk("done_seen", bus.I_fill_done || bus.D_fill_done, 1);
        tick();
    endtask

    initial begin
        bus.I_miss = 0; bus.D_miss = 0; bus.I_miss_addr = '0; bus.D_miss_addr = '0;
        @(posedge clk);
        #1;
        start_test();
        tickn(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_done", {bus.I_fill_done, bus.D_fill_done, bus.I_fill_wen, bus.D_fill_wen}, 0);
        rst_n = 1;

        bus.D_miss_addr = 16'h1236; bus.D_miss = 1;
        start_test();
        wait_done();
        bus.D_miss = 0;
        chk("t1_en_first", en_first, 1);
        chk("t1_en_last", en_last, 8);
        chk("t1_en_cnt", en_cnt, 8);
        chk("t1_addr_first", a_first, 16'h1230);
        chk("t1_addr_last", a_last, 16'h123E);
        chk("t1_wen_first", w_first, 5);
        chk("t1_wen_last", w_last, 12);
        chk("t1_d_wen", wd, 8);
        chk("t1_i_wen", wi, 0);
        chk("t1_d_done", dd, 13);

        rst_n = 0;
        tick();
        rst_n = 1;
        bus.I_miss_addr = 16'h00A4; bus.D_miss_addr = 16'h4002; bus.I_miss = 1; bus.D_miss = 1;
        start_test();
        wait_done();
        bus.D_miss = 0;
        chk("t2_d_done", dd, 13);
        chk("t2_i_done", di, -1);
        chk("t2_d_base", a_first, 16'h4000);
        start_test();
        wait_done();
        bus.I_miss = 0;
        chk("t2_i_en_first", en_first, 1);
        chk("t2_i_addr_first", a_first, 16'h00A0);
        chk("t2_i_addr_last", a_last, 16'h00AE);
        chk("t2_i_done", di, 13);
        chk("t2_i_wen", wi, 8);

        bus.I_miss_addr = 16'h2000; bus.D_miss_addr = 16'h3000; bus.I_miss = 1; bus.D_miss = 1;
        start_test();
        wait_done();
        chk("t3a_d_done", dd, 13);
        chk("t3a_base", a_first, 16'h3000);
        start_test();
        wait_done();
        chk("t3b_i_done", di, 13);
        chk("t3b_base", a_first, 16'h2000);
        start_test();
        wait_done();
        bus.I_miss = 0; bus.D_miss = 0;
        chk("t3c_d_done", dd, 13);
        chk("t3c_base", a_first, 16'h3000);

        bus.I_miss_addr = 16'h0456; bus.I_miss = 1;
        start_test();
        tickn(3);
        bus.I_miss = 0;
        wait_done();
        chk("t4_i_wen", wi, 8);
        chk("t4_i_done", di, 13);
        chk("t4_base", a_first, 16'h0450);
        tick();
        chk("t4_idle_busy", bus.busy, 0);

        bus.D_miss_addr = 16'h0800; bus.D_miss = 1;
        start_test();
        tickn(6);
        rst_n = 0; bus.D_miss = 0;
        tick();
        rst_n = 1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_mem_en", bus.mem_en, 0);
        start_test();
        tickn(4);
        chk("t5_stray_d_wen", wd, 0);
        chk("t5_stray_i_wen", wi, 0);
        chk("t5_no_issue", en_cnt, 0);

        bus.D_miss_addr = 16'hFFFE; bus.D_miss = 1;
        start_test();
        wait_done();
        bus.D_miss = 0;
        chk("t6_addr_first", a_first, 16'hFFF0);
        chk("t6_addr_last", a_last, 16'hFFFE);
        chk("t6_word_order", seq, 24'h053977);
        chk("t6_first_data", d_first, 16'hA5CC);
        chk("t6_d_done", dd, 13);
        tickn(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
